// File: rtl/rv32i_ifetch_if.sv
// Fetch-stage bus bundle: redirect input, ROM request/response
// and the valid/ready instruction handshake towards decode.
interface rv32i_ifetch_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] mem_addr;
   logic        mem_re;
   logic [31:0] mem_data;
   logic        mem_oe;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        fetch_err;

   modport master (
      input  redirect_valid, redirect_pc,
      input  mem_data, mem_oe, inst_ready,
      output mem_addr, mem_re,
      output inst_valid, inst, inst_pc, fetch_err
   );

   modport slave (
      output redirect_valid, redirect_pc,
      output mem_data, mem_oe, inst_ready,
      input  mem_addr, mem_re,
      input  inst_valid, inst, inst_pc, fetch_err
   );
endinterface

// File: rtl/rv32i_ifetch.sv
// RV32I fetch stage: PC owner, single-outstanding ROM reader.
// Optional misaligned-PC fault enabled by `define IFETCH_MISALIGN_EN.
module rv32i_ifetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input logic            clk,
   input logic            rst_n,
   rv32i_ifetch_if.master bus_io
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD
   } state_e;

   state_e      state_q;
   logic [31:0] pc_q;
   logic [31:0] mem_addr_q;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;
   logic        drop_q;
   logic        mem_re_q;
   logic        inst_valid_q;
   logic        fetch_err_q;

   logic [31:0] pc_d;
   logic        req_ok_d;
   logic        hs_d;

   assign hs_d = (state_q == HOLD) & bus_io.inst_ready;

   // Redirect beats the increment; a faulted PC never advances.
   always_comb begin
      pc_d = pc_q;
      if (bus_io.redirect_valid)
         pc_d = bus_io.redirect_pc;
      else if (hs_d && !fetch_err_q)
         pc_d = pc_q + PC_STEP;
   end

`ifdef IFETCH_MISALIGN_EN
   assign req_ok_d = (pc_d[1:0] == 2'b00);
`else
   assign req_ok_d = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         mem_addr_q   <= RESET_PC;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         drop_q       <= 1'b0;
         mem_re_q     <= 1'b0;
         inst_valid_q <= 1'b0;
         fetch_err_q  <= 1'b0;
      end else begin
         pc_q <= pc_d;
         unique case (state_q)
            IDLE: begin
               state_q    <= REQ;
               mem_re_q   <= req_ok_d;
               mem_addr_q <= pc_d;
            end
            REQ: begin
               mem_re_q <= 1'b0;
`ifdef IFETCH_MISALIGN_EN
               if (pc_q[1:0] != 2'b00) begin
                  if (bus_io.redirect_valid) begin
                     state_q    <= REQ;
                     mem_re_q   <= req_ok_d;
                     mem_addr_q <= pc_d;
                  end else begin
                     state_q      <= HOLD;
                     inst_q       <= NOP;
                     inst_pc_q    <= pc_q;
                     inst_valid_q <= 1'b1;
                     fetch_err_q  <= 1'b1;
                  end
               end else
`endif
               begin
                  state_q <= WAIT;
                  drop_q  <= bus_io.redirect_valid;
               end
            end
            WAIT: begin
               if (bus_io.mem_oe) begin
                  if (bus_io.redirect_valid || drop_q) begin
                     drop_q     <= 1'b0;
                     state_q    <= REQ;
                     mem_re_q   <= req_ok_d;
                     mem_addr_q <= pc_d;
                  end else begin
                     inst_q       <= bus_io.mem_data;
                     inst_pc_q    <= pc_q;
                     inst_valid_q <= 1'b1;
                     state_q      <= HOLD;
                  end
               end else if (bus_io.redirect_valid) begin
                  drop_q <= 1'b1;
               end
            end
            HOLD: begin
               if (bus_io.redirect_valid || bus_io.inst_ready) begin
                  inst_valid_q <= 1'b0;
                  fetch_err_q  <= 1'b0;
                  state_q      <= REQ;
                  mem_re_q     <= req_ok_d;
                  mem_addr_q   <= pc_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus_io.mem_addr   = mem_addr_q;
   assign bus_io.mem_re     = mem_re_q;
   assign bus_io.inst_valid = inst_valid_q;
   assign bus_io.inst       = inst_q;
   assign bus_io.inst_pc    = inst_pc_q;
   assign bus_io.fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_rv32i_ifetch.sv
// Bench for rv32i_ifetch: ROM model with variable latency,
// queue scoreboard of expected fetch PCs, directed + random phases.
module tb_rv32i_ifetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   rv32i_ifetch_if bus ();

   rv32i_ifetch #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (32'd4)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [31:0] rom [64];

   // ROM model state
   bit          rom_pend = 0;
   int          rom_due = 0;
   logic [31:0] rom_addr = '0;
   int          dly_fix = 0;
   bit          spur_en = 0;

   // scoreboard state
   logic [31:0] exp_q [$];
   bit          held = 0;
   bit          addr_chk = 0;
   logic [31:0] cur_pc = '0;
   logic [31:0] cur_inst = '0;
   logic        cur_err = 1'b0;
   bit          steady = 0;
   bit          last_re_ok = 0;
   int          last_re = 0;
   int          last_oe = 0;
   int          d;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic exp_err(input logic [31:0] pc);
`ifdef IFETCH_MISALIGN_EN
      return pc[1:0] != 2'b00;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] exp_inst(input logic [31:0] pc);
      if (exp_err(pc))
         return NOP;
      return rom[pc[7:2]];
   endfunction

   // ROM response driver: data for the due cycle, else garbage
   always @(posedge clk) begin
      #1;
      cyc++;
      if (rom_pend && cyc == rom_due) begin
         bus.mem_oe   = 1'b1;
         bus.mem_data = rom[rom_addr[7:2]];
         rom_pend     = 0;
      end else if (bus.mem_re && spur_en && $urandom_range(0, 1) == 1) begin
         bus.mem_oe   = 1'b1;
         bus.mem_data = $urandom;
      end else begin
         bus.mem_oe   = 1'b0;
         bus.mem_data = $urandom;
      end
   end

   // Monitor + reference model, sampled mid-cycle
   always @(negedge clk) begin
      if (!steady)
         last_re_ok = 0;
      if (!rst_n) begin
         exp_q.delete();
         exp_q.push_back(RESET_PC);
         held = 0;
         addr_chk = 0;
         last_re_ok = 0;
      end else begin
         if (bus.inst_valid) begin
            chk("no_re_in_hold", 32'(bus.mem_re), 32'd0);
            if (held) begin
               chk("hold_inst", bus.inst, cur_inst);
               chk("hold_pc", bus.inst_pc, cur_pc);
               chk("hold_err", 32'(bus.fetch_err), 32'(cur_err));
            end else if (exp_q.size() == 0) begin
               chk("exp_empty", 32'(exp_q.size()), 32'd1);
            end else begin
               cur_pc   = exp_q.pop_front();
               cur_inst = exp_inst(cur_pc);
               cur_err  = exp_err(cur_pc);
               chk("inst_pc", bus.inst_pc, cur_pc);
               chk("inst", bus.inst, cur_inst);
               chk("fetch_err", 32'(bus.fetch_err), 32'(cur_err));
               if (steady)
                  chk("valid_after_oe", 32'(cyc - last_oe), 32'd1);
            end
         end else if (held) begin
            chk("valid_dropped", 32'(bus.inst_valid), 32'd1);
         end

         if (bus.mem_re) begin
            chk("one_outstanding", 32'(rom_pend), 32'd0);
            if (exp_q.size() > 0)
               chk("req_addr", bus.mem_addr, exp_q[0]);
            if (steady && last_re_ok)
               chk("cadence", 32'(cyc - last_re), 32'(dly_fix + 3));
            last_re    = cyc;
            last_re_ok = 1;
            d = (dly_fix >= 0) ? dly_fix : int'($urandom_range(0, 4));
            rom_pend = 1;
            rom_due  = cyc + d + 1;
            rom_addr = bus.mem_addr;
            addr_chk = 1;
         end else if (rom_pend && addr_chk) begin
            chk("addr_hold", bus.mem_addr, rom_addr);
         end

         if (bus.mem_oe)
            last_oe = cyc;

         if (bus.redirect_valid) begin
            exp_q.delete();
            exp_q.push_back(bus.redirect_pc);
            held = 0;
         end else if (bus.inst_valid && bus.inst_ready) begin
            exp_q.push_back(cur_err ? cur_pc : cur_pc + 32'd4);
            held = 0;
         end else begin
            held = bus.inst_valid;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.inst_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok)
         chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_re(input string nm);
      bit ok;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.mem_re) begin
            ok = 1;
            break;
         end
      end
      if (!ok)
         chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic chk_reset();
      chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, RESET_PC);
      chk("rst_valid", 32'(bus.inst_valid), 32'd0);
      chk("rst_inst", bus.inst, 32'd0);
      chk("rst_inst_pc", bus.inst_pc, 32'd0);
      chk("rst_err", 32'(bus.fetch_err), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.inst_ready     = 1'b1;
      bus.mem_oe         = 1'b0;
      bus.mem_data       = '0;
      for (int i = 0; i < 64; i++)
         rom[i] = $urandom;
      rom[0] = 32'h0000_0013;
      rom[1] = 32'h0010_0093;

      // reset values, then steady stream at zero latency
      #2;
      chk_reset();
      repeat (3) @(posedge clk);
      #2;
      steady = 1;
      rst_n  = 1'b1;
      wait_valid("w0");
      chk("t1_inst0", bus.inst, 32'h0000_0013);
      chk("t1_pc0", bus.inst_pc, 32'h0);
      wait_valid("w1");
      chk("t1_inst1", bus.inst, 32'h0010_0093);
      chk("t1_pc1", bus.inst_pc, 32'h4);
      repeat (9) step();

      // ROM latency 3
      steady  = 0;
      dly_fix = 3;
      repeat (12) step();
      steady = 1;
      repeat (40) step();
      steady = 0;

      // decode stalls for 5 cycles
      bus.inst_ready = 1'b0;
      wait_valid("w_stall");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_valid", 32'(bus.inst_valid), 32'd1);
         chk("stall_no_re", 32'(bus.mem_re), 32'd0);
      end
      step();
      bus.inst_ready = 1'b1;

      // redirect while waiting on the ROM
      wait_re("w_re_a");
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h100;
      step();
      bus.redirect_valid = 1'b0;
      wait_re("w_re_b");
      chk("redir_wait_addr", bus.mem_addr, 32'h100);
      wait_valid("w_redir");
      chk("redir_wait_pc", bus.inst_pc, 32'h100);
      chk("redir_wait_inst", bus.inst, rom[6'h40]);

      // redirect and ready together in HOLD
      step();
      bus.inst_ready = 1'b0;
      wait_valid("w_hold");
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h40;
      bus.inst_ready     = 1'b1;
      step();
      bus.redirect_valid = 1'b0;
      wait_re("w_re_c");
      chk("redir_hold_addr", bus.mem_addr, 32'h40);

      // PC wrap past the top of the address space
      dly_fix = 0;
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'hFFFF_FFF8;
      step();
      bus.redirect_valid = 1'b0;
      wait_valid("w_wr0");
      chk("wrap_pc0", bus.inst_pc, 32'hFFFF_FFF8);
      wait_valid("w_wr1");
      chk("wrap_pc1", bus.inst_pc, 32'hFFFF_FFFC);
      wait_valid("w_wr2");
      chk("wrap_pc2", bus.inst_pc, 32'h0);

      // reset during WAIT; stale response lands after release
      dly_fix = 3;
      wait_re("w_re_d");
      step();
      rst_n = 1'b0;
      #1;
      chk_reset();
      step();
      step();
      rst_n = 1'b1;
      wait_valid("w_rst");
      chk("rst_restart_pc", bus.inst_pc, RESET_PC);
      chk("rst_restart_inst", bus.inst, rom[0]);

      // misaligned redirect target
      step();
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = 32'h102;
      step();
      bus.redirect_valid = 1'b0;
      wait_valid("w_mis");
      chk("mis_pc", bus.inst_pc, 32'h102);
`ifdef IFETCH_MISALIGN_EN
      chk("mis_err", 32'(bus.fetch_err), 32'd1);
      chk("mis_inst", bus.inst, NOP);
`else
      chk("mis_err", 32'(bus.fetch_err), 32'd0);
      chk("mis_inst", bus.inst, rom[6'h40]);
`endif

      // random traffic
      dly_fix = -1;
      spur_en = 1;
      for (int i = 0; i < 3000; i++) begin
         step();
         bus.inst_ready     = ($urandom_range(0, 9) < 7);
         bus.redirect_valid = ($urandom_range(0, 19) == 0);
         case ($urandom_range(0, 9))
            8:       bus.redirect_pc = {24'h0, 6'($urandom), 2'($urandom)};
            9:       bus.redirect_pc = {24'hFFFFFF, 6'($urandom), 2'b00};
            default: bus.redirect_pc = {24'h0, 6'($urandom), 2'b00};
         endcase
      end
      step();
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b1;
      repeat (30) step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32i_ifetch.md
Name: rv32i_ifetch

Overview:
- Instruction fetch stage that sits between the core PC logic and the instruction ROM.
- Owns the PC, issues one-cycle read requests to the ROM, and captures the returned word.
- Presents the word to decode over a valid/ready handshake.
- Handles redirects (branch/jump) at any point; a redirect discards any in-flight ROM response.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment applied to the PC after each instruction is accepted by decode.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  load redirect_pc as the next fetch PC.
- redirect_pc  in  32  redirect target (byte address).
- mem_addr  out  32  byte address to ROM; held stable from request until response.
- mem_re  out  1  one-cycle read request pulse.
- mem_data  in  32  ROM read data.
- mem_oe  in  1  ROM response valid.
- inst_valid  out  1  inst/inst_pc valid to decode.
- inst_ready  in  1  decode accepts when inst_valid & inst_ready.
- inst  out  32  fetched instruction.
- inst_pc  out  32  PC of inst.
- fetch_err  out  1  misaligned PC fault (only with IFETCH_MISALIGN_EN, else tied 0).

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=IDLE, drop=0.
  - mem_re=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_err=0.
- States: IDLE -> REQ -> WAIT -> HOLD -> REQ ...
- IDLE: one cycle after reset release, go to REQ.
- REQ:
  - mem_re=1 for exactly this cycle; mem_addr=pc.
  - Next state is WAIT.
- WAIT:
  - mem_oe is ignored in the REQ cycle.
  - The response is the first cycle in WAIT with mem_oe=1.
    - ROM DELAY=0: the cycle right after REQ.
    - ROM DELAY=N: N+1 cycles after REQ.
  - On response with drop=0: register inst=mem_data, inst_pc=pc, inst_valid=1, go to HOLD.
  - On response with drop=1: discard it, clear drop, go to REQ with the redirected pc.
- HOLD:
  - inst_valid=1; inst and inst_pc stay stable until the handshake.
  - On inst_ready=1: inst_valid=0 next cycle, pc<=pc+PC_STEP (mod 2^32, wraps 0xFFFF_FFFC->0), go to REQ.
  - mem_re stays 0 throughout.
- Throughput: at most one outstanding request; mem_re never asserts in WAIT or HOLD.
  - ROM DELAY=0 with inst_ready always 1: one instruction per 3 cycles (REQ, WAIT, HOLD).
- Redirect, by state (redirect_valid=1 in that cycle); pc<=redirect_pc in every case:
  - IDLE or REQ-to-be: the next REQ uses redirect_pc.
  - REQ: the issued request becomes stale; set drop=1.
  - WAIT with no response this cycle: set drop=1.
  - WAIT with a response in the same cycle: discard it and go to REQ (drop stays 0).
  - HOLD: drop inst_valid next cycle without a handshake, even if inst_ready=1 in the same cycle; go to REQ.
  - Redirect always wins over PC increment.
- mem_addr holds its value from REQ through WAIT.
- Reset mid-operation: immediate return to the reset values; any ROM response arriving after reset release is ignored until a new REQ.
- pc[1:0] is never altered by the block; redirect_pc is taken verbatim.

Optional Feature:
- Macro: IFETCH_MISALIGN_EN.
- Defined:
  - A REQ with pc[1:0]!=0 issues no mem_re and goes straight to HOLD with inst=32'h0000_0013 (NOP), inst_pc=pc, inst_valid=1, fetch_err=1.
  - fetch_err clears on the handshake or on a redirect.
  - Recovery requires a redirect; the PC does not advance, and the fault repeats after each handshake.
- Undefined: fetch_err tied 0; mem_addr=pc verbatim, so the ROM ignores the low bits.

Test Plan:
- Reset release, ROM DELAY=0, inst_ready=1, ROM words 0x00000013 at 0x0 and 0x00100093 at 0x4 -> mem_re pulses at addr 0x0 then 0x4; inst/inst_pc = 0x00000013/0x0, then 0x00100093/0x4; 3-cycle cadence.
- ROM DELAY=3 -> mem_oe seen 4 cycles after each mem_re; inst_valid rises the next cycle; exactly one mem_re per instruction.
- inst_ready held 0 for 5 cycles in HOLD -> inst_valid=1 with inst/inst_pc unchanged; no mem_re; pc advances only after ready=1.
- redirect_valid with redirect_pc=0x100 during WAIT (DELAY=3) -> stale response discarded, inst_valid stays 0; next mem_re addr=0x100; first inst_pc=0x100.
- redirect_valid (target 0x40) and inst_ready asserted together in HOLD -> no handshake; next mem_addr=0x40, not pc+4.
- rst_n low during WAIT, then released -> outputs at reset values; late mem_oe ignored; fetch restarts at RESET_PC. With IFETCH_MISALIGN_EN: redirect to 0x102 -> no mem_re, fetch_err=1, inst=0x00000013.
